// File: rtl/multicycle_main_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_main_control
//  Purpose  : Main control FSM for a multicycle MIPS datapath. Decodes the
//             opcode, sequences fetch/decode/execute/memory/writeback, drives
//             every datapath enable and stalls memory states on mem_ready.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_main_control #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EX    = 4'd6,
        S_R_WB    = 4'd7,
        S_BEQ_EX  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_SLTI_EX = 4'd10,
        S_I_WB    = 4'd11,
        S_J_EX    = 4'd12,
        S_TRAP    = 4'd15
    } state_t;

    state_t state_q, state_d;
    logic   w_ready;

    // With waiting disabled, memory is treated as always complete.
    assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state   = state_q;

    // State register with asynchronous reset back to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (w_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_op_lw, c_op_sw: state_d = S_MEM_ADR;
                    c_op_rtype:       state_d = S_R_EX;
                    c_op_beq:         state_d = S_BEQ_EX;
                    c_op_addi:        state_d = S_ADDI_EX;
                    c_op_slti:        state_d = S_SLTI_EX;
                    c_op_j:           state_d = S_J_EX;
                    default:          state_d = S_TRAP;
                endcase
            end
            // IR is frozen here, so the opcode still identifies lw vs sw.
            S_MEM_ADR: state_d = (opcode == c_op_sw) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (w_ready) state_d = S_MEM_WB;
            S_MEM_WR:  if (w_ready) state_d = S_FETCH;
            S_R_EX:    state_d = S_R_WB;
            S_ADDI_EX: state_d = S_I_WB;
            S_SLTI_EX: state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BEQ_EX, S_J_EX: state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore outputs (plus mem_ready qualifiers); all forced low during reset
    // so no enable can fire once rst rises, even mid-instruction.
    always_comb begin
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b11;
                    ir_write  = w_ready;
                    pc_write  = w_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_op    = 2'b11;
                end
                S_MEM_ADR, S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                end
                S_SLTI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                end
                S_MEM_RD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEM_WR: begin
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = w_ready;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_R_EX: begin
                    alu_src_a = 1'b1;
                end
                S_R_WB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BEQ_EX: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                end
                S_J_EX: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_main_control
//  Purpose  : Directed self-checking bench for multicycle_main_control.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic [3:0] state;
    logic [1:0] alu_op, alu_src_b, pc_source;
    logic       alu_src_a, pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, instr_done, illegal;
    logic [17:0] w_ctl;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_main_control #(.MEM_WAIT_EN(1'b1)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .state         (state),
        .alu_op        (alu_op),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .instr_done    (instr_done),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    assign w_ctl = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
                    iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, instr_done, illegal};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-written output table per state; r is mem_ready in that cycle.
    function automatic logic [17:0] exp_ctl(input logic [3:0] s, input logic r);
        logic [1:0] aop, srcb, pcs;
        logic srca, pw, pwc, io, mr, mw, irw, rd, m2r, rw, dn, il;
        aop = 2'b00; srcb = 2'b00; pcs = 2'b00;
        srca = 0; pw = 0; pwc = 0; io = 0; mr = 0; mw = 0; irw = 0;
        rd = 0; m2r = 0; rw = 0; dn = 0; il = 0;
        case (s)
            4'd0:        begin mr = 1; srcb = 2'b01; aop = 2'b11; irw = r; pw = r; end
            4'd1:        begin srcb = 2'b11; aop = 2'b11; end
            4'd2, 4'd9:  begin srca = 1; srcb = 2'b10; aop = 2'b11; end
            4'd10:       begin srca = 1; srcb = 2'b10; aop = 2'b10; end
            4'd3:        begin io = 1; mr = 1; end
            4'd5:        begin io = 1; mw = 1; dn = r; end
            4'd4:        begin m2r = 1; rw = 1; dn = 1; end
            4'd6:        begin srca = 1; end
            4'd7:        begin rd = 1; rw = 1; dn = 1; end
            4'd11:       begin rw = 1; dn = 1; end
            4'd8:        begin srca = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; dn = 1; end
            4'd12:       begin pw = 1; pcs = 2'b10; dn = 1; end
            4'd15:       begin il = 1; end
            default: ;
        endcase
        return {aop, srca, srcb, pcs, pw, pwc, io, mr, mw, irw, rd, m2r, rw, dn, il};
    endfunction

    // Walk one instruction from a negedge: seq holds expected states (nibble i
    // = cycle i), rdy holds mem_ready per cycle (bit i), n cycles, ndone pulses.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input logic [31:0] seq, input logic [15:0] rdy,
                             input int n, input int ndone);
        int dn_cnt = 0;
        opcode = op;
        for (int i = 0; i < n; i++) begin
            logic [3:0] es;
            es = seq[4*i +: 4];
            mem_ready = rdy[i];
            #1;
            chk($sformatf("%s_state%0d", name, i), {28'd0, state}, {28'd0, es});
            chk($sformatf("%s_ctl%0d", name, i), {14'd0, w_ctl}, {14'd0, exp_ctl(es, rdy[i])});
            if (instr_done) dn_cnt++;
            @(negedge clk);
        end
        chk({name, "_done_pulses"}, dn_cnt, ndone);
    endtask

    initial begin
        // Reset held: FETCH code, every output low (mem_read included).
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_ctl", {14'd0, w_ctl}, 32'd0);

        // Release: fetch request appears at once; no ready yet -> no ir/pc write.
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("rel_state", {28'd0, state}, 32'd0);
        chk("rel_ctl", {14'd0, w_ctl}, {14'd0, exp_ctl(4'd0, 1'b0)});
        chk("rel_mem_read", {31'd0, mem_read}, 32'd1);
        @(negedge clk);

        run_instr("rtype", 6'b000000, 32'h0000_7610, 16'h000F, 4, 1);
        // lw: ready low in DECODE/MEM_ADR (ignored) and 2 cycles in MEM_RD
        run_instr("lw", 6'b100011, 32'h0433_3210, 16'h0061, 7, 1);
        run_instr("beq", 6'b000100, 32'h0000_0810, 16'h0007, 3, 1);
        run_instr("j", 6'b000010, 32'h0000_0C10, 16'h0007, 3, 1);
        run_instr("addi", 6'b001000, 32'h0000_B910, 16'h000F, 4, 1);
        run_instr("slti", 6'b001010, 32'h0000_BA10, 16'h000F, 4, 1);
        // sw: stalled fetch for one cycle, one wait cycle in MEM_WR
        run_instr("sw", 6'b101011, 32'h0055_2100, 16'h002E, 6, 1);

        // lw abandoned by reset during a MEM_RD wait
        run_instr("lw_abort", 6'b100011, 32'h0000_3210, 16'h0007, 4, 0);
        mem_ready = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_state", {28'd0, state}, 32'd0);
        chk("abort_ctl", {14'd0, w_ctl}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Illegal opcode traps and holds regardless of mem_ready
        run_instr("ill", 6'b111111, 32'h0000_0F10, 16'h0003, 3, 0);
        for (int k = 0; k < 12; k++) begin
            mem_ready = k[0];
            #1;
            chk($sformatf("trap_state%0d", k), {28'd0, state}, 32'd15);
            chk($sformatf("trap_illegal%0d", k), {31'd0, illegal}, 32'd1);
            @(negedge clk);
        end

        // Reset recovers from TRAP
        #2 rst = 1'b1;
        #1;
        chk("trap_rst_state", {28'd0, state}, 32'd0);
        chk("trap_rst_ctl", {14'd0, w_ctl}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("post_trap_ctl", {14'd0, w_ctl}, {14'd0, exp_ctl(4'd0, 1'b1)});
        @(negedge clk);
        #1;
        chk("post_trap_decode", {28'd0, state}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_main_control.md
# multicycle_main_control

Multicycle main control unit for the MIPS datapath. It decodes the instruction opcode and sequences the instruction through fetch, decode, execute, memory and writeback states. It is the producing end of the 2-bit `alu_op` interface that the ALU control decoder consumes. It drives every datapath enable, and it stalls on a ready handshake in memory states.

## Interface
- `MEM_WAIT_EN`, default 1 — 1: memory states hold until `mem_ready`; 0: `mem_ready` is treated as constant 1.
- `clk`  in  1  — single system clock; all state updates occur on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `opcode`  in  6  — instr[31:26] from the instruction register; valid from DECODE onward.
- `mem_ready`  in  1  — memory completion for the current read or write.
- `state`  out  4  — current state code, for debug.
- `alu_op`  out  2  — ALU operation class: 00 R-type (decoded from func), 01 sub (beq), 10 slt (slti), 11 add (addi/lw/sw/PC arithmetic).
- `alu_src_a`  out  1  — ALU A select: 0 = PC, 1 = rs register.
- `alu_src_b`  out  2  — ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pc_source`  out  2  — next PC select: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `pc_write`, `pc_write_cond`, `iord`, `mem_read`, `mem_write`, `ir_write`, `reg_dst`, `mem_to_reg`, `reg_write`  out  1 each  — datapath enables and selects.
- `instr_done`  out  1  — one-cycle pulse on the final cycle of each instruction.
- `illegal`  out  1  — high while the FSM is in TRAP.

## Operation
- Opcodes: R-type 000000, addi 001000, slti 001010, lw 100011, sw 101011, beq 000100, j 000010. Any other opcode is illegal.
- State codes: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EX 6, R_WB 7, BEQ_EX 8, ADDI_EX 9, SLTI_EX 10, I_WB 11, J_EX 12, TRAP 15. Codes 13 and 14 are unused; if entered, the next state is FETCH.
- Transitions:
  - FETCH → DECODE when `mem_ready`, else stay.
  - DECODE → MEM_ADR (lw/sw), R_EX, BEQ_EX, ADDI_EX, SLTI_EX, J_EX or TRAP, according to `opcode`.
  - MEM_ADR → MEM_RD (lw) or MEM_WR (sw). The opcode is re-read in this state; it is stable because `ir_write` = 0.
  - MEM_RD → MEM_WB when `mem_ready`. MEM_WR → FETCH when `mem_ready`.
  - R_EX → R_WB; ADDI_EX and SLTI_EX → I_WB.
  - MEM_WB, R_WB, I_WB, BEQ_EX and J_EX → FETCH.
  - TRAP → TRAP until reset.
- Outputs are Moore, except where a condition is stated. Any output not listed for a state is 0.
  - FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=11, `pc_source`=00, `ir_write`=`pc_write`=`mem_ready`.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=11 (branch target is computed into ALUOut).
  - MEM_ADR, ADDI_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11.
  - SLTI_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10.
  - MEM_RD: `iord`=1, `mem_read`=1.
  - MEM_WR: `iord`=1, `mem_write`=1, `instr_done`=`mem_ready`.
  - MEM_WB: `mem_to_reg`=1, `reg_write`=1, `reg_dst`=0, `instr_done`=1.
  - R_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00.
  - R_WB: `reg_dst`=1, `reg_write`=1, `instr_done`=1.
  - I_WB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1, `instr_done`=1.
  - BEQ_EX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1.
  - J_EX: `pc_write`=1, `pc_source`=10, `instr_done`=1.
  - TRAP: `illegal`=1.

## Timing
- Reset: while `rst`=1, `state` is FETCH (0) and every other output is forced to 0, including `mem_read`. The first fetch request appears in the first cycle after `rst` deasserts.
- Reset mid-instruction, including during a memory wait: the instruction is abandoned immediately, with no write enable asserted after `rst` rises.
- Latency with `mem_ready` held at 1:
  - j and beq: 3 cycles.
  - R-type, addi, slti and sw: 4 cycles.
  - lw: 5 cycles.
  - Each memory state extends by one cycle per cycle of `mem_ready`=0.
- `mem_ready` is sampled only in FETCH, MEM_RD and MEM_WR; it is ignored in all other states.
- `ir_write` and `pc_write` in FETCH occur in the same cycle as `mem_ready`, never earlier.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `state`=0 and all outputs 0 at once. Release `rst` → next cycle `mem_read`=1, `alu_src_b`=01, `alu_op`=11.
- R-type, `opcode`=000000, `mem_ready`=1 → states 0,1,6,7,0. `alu_op`=00 in R_EX; `reg_dst`=1 and `reg_write`=1 in R_WB; one `instr_done` pulse.
- lw, `opcode`=100011, `mem_ready` low for 2 cycles in MEM_RD → states 0,1,2,3,3,3,4,0. `iord`=1 throughout MEM_RD; `mem_to_reg`=1 in MEM_WB.
- beq then j: beq gives `alu_op`=01, `pc_write_cond`=1, `pc_source`=01 in state 8. j gives `pc_write`=1, `pc_source`=10 in state 12. Each takes 3 cycles.
- slti (001010) gives `alu_op`=10 in state 10; addi (001000) gives `alu_op`=11 in state 9. Both then pass through I_WB with `reg_write`=1 and `reg_dst`=0.
- Illegal `opcode`=111111 → state 15 with `illegal`=1 held for 10 or more cycles regardless of `mem_ready`. `rst` then returns the FSM to FETCH.
